// File: rtl/serial_addsub.sv
// serial_addsub: bit-serial two's-complement add/subtract, LSB first, WIDTH cycles per operation.
// Define SERIAL_ADDSUB_OVF_EN to add the registered signed-overflow output ovf.
module serial_addsub #(
  parameter int WIDTH = 24
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             sub,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] s,
  output logic             cout
`ifdef SERIAL_ADDSUB_OVF_EN
  ,
  output logic             ovf
`endif
);
  localparam int CW = $clog2(WIDTH);
  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
  state_t state, state_n;
  logic [WIDTH-1:0] ra, rb;
  logic [CW-1:0] cnt;
  logic c, sb, cn, last;
  assign sb = ra[0] ^ rb[0] ^ c;
  assign cn = (ra[0] & rb[0]) | (ra[0] & c) | (rb[0] & c);
  assign last = cnt == CW'(WIDTH - 1);
  assign in_ready = state == IDLE;
  assign out_valid = state == DONE;
  always_comb begin
    state_n = state;
    if (state == IDLE && in_valid) state_n = RUN;
    if (state == RUN && last) state_n = DONE;
    if (state == DONE && out_ready) state_n = IDLE;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      ra <= '0;
      rb <= '0;
      s <= '0;
      c <= 1'b0;
      cnt <= '0;
      cout <= 1'b0;
`ifdef SERIAL_ADDSUB_OVF_EN
      ovf <= 1'b0;
`endif
    end else begin
      state <= state_n;
      if (state == IDLE && in_valid) begin
        ra <= a;
        rb <= sub ? ~b : b;
        c <= sub;
        cnt <= '0;
      end
      if (state == RUN) begin
        ra <= ra >> 1;
        rb <= rb >> 1;
        s <= {sb, s[WIDTH-1:1]};
        c <= cn;
        cnt <= cnt + 1'b1;
        if (last) begin
          cout <= cn;
`ifdef SERIAL_ADDSUB_OVF_EN
          ovf <= c ^ cn;
`endif
        end
      end
    end
  end
endmodule

// File: tb/tb_serial_addsub.sv
// tb_serial_addsub: directed-vector self-checking bench for serial_addsub at WIDTH=8.
module tb_serial_addsub;
  logic clk = 1'b0;
  logic rst, in_valid, in_ready, sub, out_valid, out_ready, cout;
  logic [7:0] a, b, s;
  int checks = 0;
  int errors = 0;
`ifdef SERIAL_ADDSUB_OVF_EN
  logic ovf;
`endif
  serial_addsub #(.WIDTH(8)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .a(a), .b(b), .sub(sub), .out_valid(out_valid), .out_ready(out_ready),
    .s(s), .cout(cout)
`ifdef SERIAL_ADDSUB_OVF_EN
    , .ovf(ovf)
`endif
  );
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0h expected %0h", tag, got, exp);
    end
  endtask
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic wait_done(input string tag, input bit toggle);
    int n = 0;
    while (!out_valid && n < 20) begin
      tick();
      n++;
      if (toggle) begin
        a = 8'($urandom);
        b = 8'($urandom);
        sub = 1'($urandom);
      end
    end
    chk({tag, "_lat"}, n, 8);
  endtask
  task automatic res(input string tag, input logic [7:0] es, input logic ec, input logic eo);
    chk({tag, "_s"}, s, es);
    chk({tag, "_cout"}, cout, ec);
`ifdef SERIAL_ADDSUB_OVF_EN
    chk({tag, "_ovf"}, ovf, eo);
`else
    if (eo === 1'bx) chk({tag, "_ovf"}, 0, 1);
`endif
  endtask
  task automatic op(input string tag, input logic [7:0] aa, input logic [7:0] bb, input logic ss,
                    input logic [7:0] es, input logic ec, input logic eo, input bit toggle);
    a = aa;
    b = bb;
    sub = ss;
    in_valid = 1'b1;
    chk({tag, "_rdy"}, in_ready, 1);
    tick();
    in_valid = 1'b0;
    wait_done(tag, toggle);
    res(tag, es, ec, eo);
    tick();
    chk({tag, "_drop"}, {in_ready, out_valid}, 2'b10);
  endtask
  initial begin
    bit seen;
    rst = 1'b1;
    in_valid = 1'b0;
    out_ready = 1'b1;
    a = '0;
    b = '0;
    sub = 1'b0;
    repeat (2) tick();
    rst = 1'b0;
    chk("reset_hs", {in_ready, out_valid}, 2'b10);
    res("reset", 8'h00, 1'b0, 1'b0);
    op("add_5_3", 8'h05, 8'h03, 1'b0, 8'h08, 1'b0, 1'b0, 0);
    op("add_ff_1", 8'hFF, 8'h01, 1'b0, 8'h00, 1'b1, 1'b0, 0);
    op("add_7f_1", 8'h7F, 8'h01, 1'b0, 8'h80, 1'b0, 1'b1, 0);
    op("sub_3_5", 8'h03, 8'h05, 1'b1, 8'hFE, 1'b0, 1'b0, 0);
    op("sub_5_5", 8'h05, 8'h05, 1'b1, 8'h00, 1'b1, 1'b0, 0);
    op("sub_80_1", 8'h80, 8'h01, 1'b1, 8'h7F, 1'b1, 1'b1, 0);
    out_ready = 1'b0;
    a = 8'h40;
    b = 8'h40;
    sub = 1'b0;
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    wait_done("bp", 0);
    a = 8'h10;
    b = 8'h20;
    in_valid = 1'b1;
    for (int i = 0; i < 5; i++) begin
      tick();
      chk("bp_hold_hs", {in_ready, out_valid}, 2'b01);
      res("bp_hold", 8'h80, 1'b0, 1'b1);
    end
    out_ready = 1'b1;
    tick();
    chk("bp_release", {in_ready, out_valid}, 2'b10);
    tick();
    in_valid = 1'b0;
    chk("bp_accept", in_ready, 0);
    wait_done("bp_next", 0);
    res("bp_next", 8'h30, 1'b0, 1'b0);
    tick();
    a = 8'h55;
    b = 8'h0A;
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    repeat (4) tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("rst_hs", {in_ready, out_valid}, 2'b10);
    res("rst", 8'h00, 1'b0, 1'b0);
    seen = 0;
    for (int i = 0; i < 12; i++) begin
      tick();
      seen |= out_valid;
    end
    chk("rst_no_result", seen, 0);
    op("post_rst", 8'h01, 8'h01, 1'b0, 8'h02, 1'b0, 1'b0, 0);
    op("toggle", 8'h12, 8'h34, 1'b0, 8'h46, 1'b0, 1'b0, 1);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
